pixel_frame_tx: RTL and testbench
=================================

# pixel_frame_tx

Transmit side of the forward-pass pixel stream. Holds one image in a local buffer, then emits it as a framed raster: a two-byte dimension header bracketed by `frame_start_dim`/`frame_end_dim`, then ROWS lines of COLS pixels marked by `frame_start`, `line_start` and `frame_end`, all qualified by `ena`. It sits between the host/testbench image loader and `forward_pass_top`, and drives that block's `*_in` stream inputs one-to-one.

## Interface
- `ROWS`, default 28: image lines per frame (1..255).
- `COLS`, default 28: pixels per line (1..255).
- `PIX_W`, default 8: pixel width; signed two's complement.
- `LINE_GAP`, default 2: idle cycles (`ena`=0) between consecutive lines (0 allowed).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  $clog2(ROWS*COLS)  raster address, row*COLS+col.
- `wr_data`  in  PIX_W  pixel value.
- `start`  in  1  one-cycle request to transmit the buffered image.
- `hold`  in  1  back-pressure; freezes transmission.
- `busy`  out  1  high from start acceptance to end of frame.
- `done`  out  1  one-cycle pulse after last pixel.
- `frame_start_dim`, `frame_end_dim`  out  1 each  header delimiters.
- `frame_start`, `line_start`, `frame_end`  out  1 each  raster markers.
- `ena`  out  1  data-valid for `ima` and all markers.
- `ima`  out  PIX_W  header byte or pixel.

## Operation
- States: IDLE, HDR0, HDR1, PIX, LGAP, FIN.
- IDLE: `start`=1 → HDR0, `busy`=1. `start` is ignored in every other state.
- HDR0: `ena`=1, `ima`=ROWS, `frame_start_dim`=1 → HDR1.
- HDR1: `ena`=1, `ima`=COLS, `frame_end_dim`=1 → PIX. Row and column counters are 0.
- PIX: `ena`=1, `ima`=buf[row*COLS+col].
  - `line_start`=1 when col=0.
  - `frame_start`=1 when row=0 and col=0.
  - `frame_end`=1 when row=ROWS-1 and col=COLS-1.
  - col wraps at COLS-1 and row increments. From there: last pixel → FIN; else LINE_GAP>0 → LGAP; else stay in PIX.
- LGAP: `ena`=0 for exactly LINE_GAP cycles → PIX.
- FIN: `done`=1 and `busy`=0 for one cycle → IDLE.
- `hold`=1 in any non-IDLE, non-FIN state:
  - `ena` and all markers forced to 0.
  - State, counters and the LGAP count are frozen. `ima` holds its last value.
  - Transmission resumes exactly where it stopped; no beat is lost or duplicated.
  - ROWS=COLS=1: `frame_start`, `line_start` and `frame_end` are all high on the single pixel.
- Markers are asserted only when `ena`=1.
- Buffer writes:
  - Accepted only when `busy`=0; `wr_en` while busy is dropped.
  - Addresses ≥ ROWS*COLS are ignored.
  - A write and `start` in the same IDLE cycle: the write lands before the first pixel read.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE. Buffer contents are not reset.
- `start` sampled at edge N → HDR0 outputs visible after edge N+1. The first pixel appears two beats after HDR0, assuming no hold.
- Unheld frame length from HDR0 to `frame_end`: 2 + ROWS*COLS + (ROWS-1)*LINE_GAP cycles. `done` follows one cycle after `frame_end`.
- `hold` sampled at edge K takes effect on outputs after edge K+1; release has the same one-cycle delay.
- `rst_n` low mid-frame: outputs drop to 0 asynchronously, with no `done` pulse. The next `start` after reset transmits the current buffer.

## Structure
- Package `cnn_stream_pkg` holds:
  - state enum `tx_state_e`;
  - default ROWS/COLS/PIX_W constants;
  - header byte order (rows first, then cols).
- Sub-module `frame_buffer`: ROWS*COLS × PIX_W, one synchronous write port, one read port. The read address is driven from next-state counters so read data is ready for the output register.
- The top holds the FSM, counters and output registers.

## Test plan
- ROWS=3, COLS=4, LINE_GAP=2, buffer = addr-1 (signed), one `start` → expect:
  - `ena` beats: 3, 4, -1..10;
  - `frame_start` on the -1 beat; `line_start` on -1, 3, 7; `frame_end` on 10;
  - 2 idle cycles between lines; `done` 19 cycles after HDR0.
- Same image with LINE_GAP=0 → 14 contiguous `ena` cycles, `done` on cycle 15.
- `hold` high for 5 cycles starting at pixel 6 → same beat sequence; `frame_end` 5 cycles later; markers never high while `ena`=0.
- `wr_en` to addr 0 with data 0x55 while busy, plus a second `start` mid-frame → current frame unchanged; no second frame. Next run still emits -1 at addr 0.
- `rst_n` pulsed low during the second line → all outputs 0 immediately, no `done`. Next `start` produces a full correct frame.
- ROWS=COLS=1 → beats 1, 1, pixel; all three raster markers high on the pixel.

Source files
------------

// File: rtl/cnn_stream_pkg.sv
// cnn_stream_pkg: shared types and constants for the forward-pass pixel stream.
//   tx_state_e    : transmitter FSM states
//   DEF_*         : default frame geometry and pixel width
//   hdr_byte()    : selects the header byte for a given header beat index
package cnn_stream_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    PIX  = 3'd3,
    LGAP = 3'd4,
    FIN  = 3'd5
  } tx_state_e;

  localparam int DEF_ROWS     = 28;
  localparam int DEF_COLS     = 28;
  localparam int DEF_PIX_W    = 8;
  localparam int DEF_LINE_GAP = 2;

  // The dimension header is sent rows first, then cols.
  localparam bit HDR_ROWS_FIRST = 1'b1;

  function automatic logic [7:0] hdr_byte(input logic idx, input int rows, input int cols);
    logic first_is_rows;
    first_is_rows = (idx == 1'b0) ? HDR_ROWS_FIRST : !HDR_ROWS_FIRST;
    return first_is_rows ? 8'(rows) : 8'(cols);
  endfunction

endpackage

// File: rtl/pixel_frame_tx_if.sv
// pixel_frame_tx_if: framed pixel stream from pixel_frame_tx to forward_pass_top.
//   ena              : beat valid; qualifies ima and every marker
//   ima              : header byte or signed pixel
//   frame_start_dim  : first header beat (rows)
//   frame_end_dim    : second header beat (cols)
//   frame_start      : first pixel of the frame
//   line_start       : first pixel of each line
//   frame_end        : last pixel of the frame
// Handshake: there is no ready; a beat is transferred on every cycle with
// ena=1 and markers are only ever high together with ena. Flow control is the
// separate hold input of the transmitter, which acts one cycle after it is
// sampled and neither drops nor repeats a beat.
interface pixel_frame_tx_if #(
  parameter int PIX_W = 8
);
  logic             ena;
  logic [PIX_W-1:0] ima;
  logic             frame_start_dim;
  logic             frame_end_dim;
  logic             frame_start;
  logic             line_start;
  logic             frame_end;

  modport master (
    output ena, ima, frame_start_dim, frame_end_dim,
           frame_start, line_start, frame_end
  );

  modport slave (
    input ena, ima, frame_start_dim, frame_end_dim,
          frame_start, line_start, frame_end
  );
endinterface

// File: rtl/frame_buffer.sv
// frame_buffer: one-image pixel store, DEPTH x PIX_W.
//   clk      : clock
//   wr_en    : write strobe (already qualified by the caller)
//   wr_addr  : raster write address
//   wr_data  : pixel to write
//   rd_addr  : read address, registered into rd_data every cycle
//   rd_data  : pixel at rd_addr from the previous edge
// Contents are not reset.
module frame_buffer #(
  parameter int DEPTH = 784,
  parameter int PIX_W = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_frame_tx.sv
// pixel_frame_tx: buffers one image and transmits it as a framed raster.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_en/addr/data    : image load port, accepted only while not busy
//   start              : request to transmit the buffered image (IDLE only)
//   hold               : back-pressure, freezes transmission one cycle later
//   busy               : frame in progress
//   done               : one-cycle pulse after the last pixel
//   tx                 : framed output stream (header + raster + markers)
//   state_dbg          : current FSM state
// The state register names the beat to be produced on the next edge; all
// stream outputs are registered from it, so outputs trail state by one cycle.
module pixel_frame_tx
  import cnn_stream_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int LINE_GAP = DEF_LINE_GAP,
  localparam int NPIX    = ROWS * COLS,
  // A 1x1 image still needs a one-bit address port.
  localparam int AW      = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  pixel_frame_tx_if.master tx,
  output tx_state_e        state_dbg
);

  tx_state_e        state, nxt_state;
  logic [7:0]       row, col, nxt_row, nxt_col;
  logic [AW-1:0]    addr, nxt_addr;
  logic [15:0]      gap_cnt, nxt_gap;
  logic             hold_q;
  logic             frozen;
  logic             wr_ok;
  logic [PIX_W-1:0] rd_data;

  assign state_dbg = state;

  // hold is registered first, which gives the one-cycle response latency.
  assign frozen = hold_q && (state inside {HDR0, HDR1, PIX, LGAP});

  assign wr_ok = wr_en && !busy && (32'(wr_addr) < NPIX);

  // Read address follows the next-state counters so the pixel for the next
  // PIX beat is sitting in rd_data when the output register loads it.
  frame_buffer #(
    .DEPTH (NPIX),
    .PIX_W (PIX_W),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (nxt_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    nxt_addr  = addr;
    nxt_gap   = gap_cnt;
    if (!frozen) begin
      case (state)
        IDLE: begin
          if (start) begin
            nxt_state = HDR0;
            nxt_row   = '0;
            nxt_col   = '0;
            nxt_addr  = '0;
            nxt_gap   = '0;
          end
        end
        HDR0: nxt_state = HDR1;
        HDR1: nxt_state = PIX;
        PIX: begin
          if (col == 8'(COLS - 1)) begin
            nxt_col = '0;
            if (row == 8'(ROWS - 1)) begin
              nxt_state = FIN;
            end else begin
              nxt_row  = row + 8'd1;
              nxt_addr = addr + AW'(1);
              if (LINE_GAP > 0) begin
                nxt_state = LGAP;
                nxt_gap   = '0;
              end
            end
          end else begin
            nxt_col  = col + 8'd1;
            nxt_addr = addr + AW'(1);
          end
        end
        LGAP: begin
          if (gap_cnt == 16'(LINE_GAP - 1)) begin
            nxt_state = PIX;
          end else begin
            nxt_gap = gap_cnt + 16'd1;
          end
        end
        FIN:     nxt_state = IDLE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      row                <= '0;
      col                <= '0;
      addr               <= '0;
      gap_cnt            <= '0;
      hold_q             <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      tx.ena             <= 1'b0;
      tx.ima             <= '0;
      tx.frame_start_dim <= 1'b0;
      tx.frame_end_dim   <= 1'b0;
      tx.frame_start     <= 1'b0;
      tx.line_start      <= 1'b0;
      tx.frame_end       <= 1'b0;
    end else begin
      hold_q  <= hold;
      state   <= nxt_state;
      row     <= nxt_row;
      col     <= nxt_col;
      addr    <= nxt_addr;
      gap_cnt <= nxt_gap;

      // Strobes default low; ima keeps its last value when not driven.
      done               <= 1'b0;
      tx.ena             <= 1'b0;
      tx.frame_start_dim <= 1'b0;
      tx.frame_end_dim   <= 1'b0;
      tx.frame_start     <= 1'b0;
      tx.line_start      <= 1'b0;
      tx.frame_end       <= 1'b0;

      if (!frozen) begin
        case (state)
          IDLE: begin
            if (start) busy <= 1'b1;
          end
          HDR0: begin
            tx.ena             <= 1'b1;
            tx.ima             <= PIX_W'(hdr_byte(1'b0, ROWS, COLS));
            tx.frame_start_dim <= 1'b1;
          end
          HDR1: begin
            tx.ena           <= 1'b1;
            tx.ima           <= PIX_W'(hdr_byte(1'b1, ROWS, COLS));
            tx.frame_end_dim <= 1'b1;
          end
          PIX: begin
            tx.ena         <= 1'b1;
            tx.ima         <= rd_data;
            tx.line_start  <= (col == 8'd0);
            tx.frame_start <= (row == 8'd0) && (col == 8'd0);
            tx.frame_end   <= (row == 8'(ROWS - 1)) && (col == 8'(COLS - 1));
          end
          FIN: begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_tx.sv
// tb_pixel_frame_tx: three transmitter instances (3x4 gap 2, 3x4 gap 0, 1x1)
// checked cycle by cycle against a frame model built from the raster rules.
module tb_pixel_frame_tx;
  import cnn_stream_pkg::*;

  typedef struct packed {
    logic       ena;
    logic       fsd;
    logic       fed;
    logic       fs;
    logic       ls;
    logic       fe;
    logic       done;
    logic       busy;
    logic [7:0] ima;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic       wr_en_a = 1'b0, wr_en_b = 1'b0, wr_en_c = 1'b0;
  logic [3:0] wr_addr_a = '0, wr_addr_b = '0;
  logic [0:0] wr_addr_c = '0;
  logic [7:0] wr_data = '0;
  logic       hold = 1'b0;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
  tx_state_e  st_a, st_b, st_c;

  pixel_frame_tx_if #(.PIX_W(8)) if_a ();
  pixel_frame_tx_if #(.PIX_W(8)) if_b ();
  pixel_frame_tx_if #(.PIX_W(8)) if_c ();

  pixel_frame_tx #(.ROWS(3), .COLS(4), .PIX_W(8), .LINE_GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data),
    .start(start_a), .hold(hold), .busy(busy_a), .done(done_a), .tx(if_a.master),
    .state_dbg(st_a));

  pixel_frame_tx #(.ROWS(3), .COLS(4), .PIX_W(8), .LINE_GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data),
    .start(start_b), .hold(hold), .busy(busy_b), .done(done_b), .tx(if_b.master),
    .state_dbg(st_b));

  pixel_frame_tx #(.ROWS(1), .COLS(1), .PIX_W(8), .LINE_GAP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data),
    .start(start_c), .hold(hold), .busy(busy_c), .done(done_c), .tx(if_c.master),
    .state_dbg(st_c));

  obs_t obs_a, obs_b, obs_c, obs;
  int   sel = 0;
  assign obs_a = {if_a.ena, if_a.frame_start_dim, if_a.frame_end_dim, if_a.frame_start,
                  if_a.line_start, if_a.frame_end, done_a, busy_a, if_a.ima};
  assign obs_b = {if_b.ena, if_b.frame_start_dim, if_b.frame_end_dim, if_b.frame_start,
                  if_b.line_start, if_b.frame_end, done_b, busy_b, if_b.ima};
  assign obs_c = {if_c.ena, if_c.frame_start_dim, if_c.frame_end_dim, if_c.frame_start,
                  if_c.line_start, if_c.frame_end, done_c, busy_c, if_c.ima};
  always_comb begin
    case (sel)
      0:       obs = obs_a;
      1:       obs = obs_b;
      default: obs = obs_c;
    endcase
  end

  // ---------------- reference model state ----------------
  int         rows_of [3] = '{3, 3, 1};
  int         cols_of [3] = '{4, 4, 1};
  int         gap_of  [3] = '{2, 0, 1};
  logic [7:0] img [3][16];
  logic [15:0] exp_q[$];

  int checks   = 0;
  int failures = 0;

  // ---------------- driver tasks ----------------
  task automatic drive_start(input int s, input logic v);
    case (s)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic drive_wr(input int s, input logic en, input int addr, input logic [7:0] d);
    wr_data = d;
    case (s)
      0:       begin wr_en_a = en; wr_addr_a = 4'(addr); end
      1:       begin wr_en_b = en; wr_addr_b = 4'(addr); end
      default: begin wr_en_c = en; wr_addr_c = 1'(addr); end
    endcase
  endtask

  // Idle-time write; the model only keeps in-range addresses.
  task automatic write_pix(input int s, input int addr, input logic [7:0] d);
    @(negedge clk);
    drive_wr(s, 1'b1, addr, d);
    @(negedge clk);
    drive_wr(s, 1'b0, 0, 8'h00);
    if (addr < rows_of[s] * cols_of[s]) img[s][addr] = d;
  endtask

  // Trace index of pixel p: acceptance cycle, two header beats, then pixels
  // with the line gaps of every completed line in front of it.
  function automatic int pix_idx(input int s, input int p);
    return 3 + p + (p / cols_of[s]) * gap_of[s];
  endfunction

  // Expected per-cycle trace starting with the cycle after start is sampled.
  task automatic build_frame(input int s, input int hold_at, input int hold_len);
    obs_t e;
    int   r_n, c_n;
    r_n = rows_of[s];
    c_n = cols_of[s];
    exp_q.delete();
    e = '0; e.busy = 1'b1;
    exp_q.push_back(e);
    e.ena = 1'b1; e.fsd = 1'b1; e.ima = 8'(r_n);
    exp_q.push_back(e);
    e.fsd = 1'b0; e.fed = 1'b1; e.ima = 8'(c_n);
    exp_q.push_back(e);
    for (int r = 0; r < r_n; r++) begin
      for (int c = 0; c < c_n; c++) begin
        e = '0; e.busy = 1'b1; e.ena = 1'b1;
        e.ima = img[s][r * c_n + c];
        e.ls  = (c == 0);
        e.fs  = (r == 0) && (c == 0);
        e.fe  = (r == r_n - 1) && (c == c_n - 1);
        exp_q.push_back(e);
      end
      if (r < r_n - 1) begin
        e = '0; e.busy = 1'b1;
        repeat (gap_of[s]) exp_q.push_back(e);
      end
    end
    e = '0; e.done = 1'b1;
    exp_q.push_back(e);
    e = '0;
    repeat (6) exp_q.push_back(e);
    if (hold_len > 0) begin
      e = '0; e.busy = 1'b1;
      repeat (hold_len) exp_q.insert(hold_at, e);
    end
  endtask

  // Starts a frame on instance s and compares every cycle against the model.
  // hold_at/hold_len: trace index and length of the hold bubble (len 0 = none).
  // inj_at: after this index, a busy-time write to addr 0 and a second start.
  // abort_at: stop comparing after this index (-1 = run the whole trace).
  task automatic run_frame(input int s, input int hold_at, input int hold_len,
                           input int inj_at, input int abort_at, input string tag);
    obs_t        e, o;
    logic [15:0] mask;
    build_frame(s, hold_at, hold_len);
    sel = s;
    @(negedge clk);
    drive_start(s, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) drive_start(s, 1'b0);
      e = exp_q[i];
      o = obs;
      mask = e.ena ? 16'hFFFF : 16'hFF00;
      checks++;
      if ((o & mask) !== (e & mask)) begin
        failures++;
        $display("FAIL %s idx=%0d got=%h exp=%h (ena,fsd,fed,fs,ls,fe,done,busy|ima)",
                 tag, i, o, e);
      end
      if (hold_len > 0) hold = (i >= hold_at - 2) && (i < hold_at - 2 + hold_len);
      if (i == inj_at) begin
        drive_wr(s, 1'b1, 0, 8'h55);
        drive_start(s, 1'b1);
      end else if (inj_at >= 0 && i == inj_at + 1) begin
        drive_wr(s, 1'b0, 0, 8'h00);
        drive_start(s, 1'b0);
      end
      if (i == abort_at) break;
    end
    hold = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs_a !== 16'h0 || st_a !== IDLE) begin
      failures++; $display("FAIL reset_a got=%h st=%0d exp=0000 st=0", obs_a, st_a);
    end
    checks++;
    if (obs_b !== 16'h0 || st_b !== IDLE) begin
      failures++; $display("FAIL reset_b got=%h st=%0d exp=0000 st=0", obs_b, st_b);
    end
    checks++;
    if (obs_c !== 16'h0 || st_c !== IDLE) begin
      failures++; $display("FAIL reset_c got=%h st=%0d exp=0000 st=0", obs_c, st_c);
    end
    rst_n = 1'b1;
  endtask

  task automatic load_ramp();
    for (int a = 0; a < 12; a++) begin
      write_pix(0, a, 8'(a - 1));
      write_pix(1, a, 8'(a - 1));
    end
    write_pix(2, 0, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_frame_gap();
    run_frame(0, -1, 0, -1, -1, "frame_gap");
  endtask

  task automatic test_frame_nogap();
    run_frame(1, -1, 0, -1, -1, "frame_nogap");
  endtask

  task automatic test_hold();
    run_frame(0, pix_idx(0, 6), 5, -1, -1, "hold_px6");
  endtask

  task automatic test_busy_ignore();
    run_frame(0, -1, 0, 10, -1, "busy_ignore");
    run_frame(0, -1, 0, -1, -1, "after_busy");
  endtask

  task automatic test_reset_mid();
    run_frame(0, -1, 0, -1, pix_idx(0, 5), "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== 16'h0 || st_a !== IDLE) begin
      failures++; $display("FAIL async_reset got=%h st=%0d exp=0000 st=0", obs_a, st_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== 16'h0) begin
        failures++; $display("FAIL post_reset_idle cyc=%0d got=%h exp=0000", i, obs_a);
      end
    end
    run_frame(0, -1, 0, -1, -1, "post_reset");
  endtask

  task automatic test_single();
    write_pix(2, 1, 8'hA5);   // out of range for a 1x1 image
    run_frame(2, -1, 0, -1, -1, "single");
    run_frame(2, pix_idx(2, 0), 3, -1, -1, "single_hold");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int s;
      int hp;
      s = k % 2;
      for (int a = 0; a < 12; a++) write_pix(s, a, 8'($urandom_range(0, 255)));
      write_pix(s, $urandom_range(12, 15), 8'($urandom_range(0, 255)));
      hp = $urandom_range(0, 11);
      run_frame(s, pix_idx(s, hp), $urandom_range(0, 6), -1, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    load_ramp();
    test_frame_gap();
    test_frame_nogap();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
    test_single();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
